// File: rtl/tdma_nd_pkg.sv
// tdma_nd_pkg: shared types for the N-dimensional tDMA address generator
package tdma_nd_pkg;
  localparam int NUM_DIM  = 4;
  localparam int ADDR_W   = 64;
  localparam int DIM_W    = 32;
  localparam int STRIDE_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DIM_W-1:0] dim_t;
  typedef logic [STRIDE_W-1:0] stride_t;
  typedef struct packed {
    addr_t                   addr;
    dim_t    [NUM_DIM-1:0]   shape;
    stride_t [NUM_DIM-1:0]   stride;
  } nd_req_t;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/tdma_nd_dim_ctr.sv
// tdma_nd_dim_ctr: per-dimension loop counter with final-index flag
module tdma_nd_dim_ctr #(
  parameter int DimWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic                wrap_i,
  input  logic [DimWidth-1:0] shape_i,
  output logic                final_o
);
  logic [DimWidth-1:0] ctr_q, ctr_d;
  // a zero shape behaves as one, so its only index is 0
  assign final_o = ctr_q == ((shape_i == '0) ? '0 : shape_i - DimWidth'(1));
  // clear on accept or when a higher dimension advances, else count up
  always_comb ctr_d = (clr_i || wrap_i) ? '0 : inc_i ? ctr_q + DimWidth'(1) : ctr_q;
  // counter register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ctr_q <= '0;
    else ctr_q <= ctr_d;
endmodule

// File: rtl/tdma_nd_addr_gen.sv
// tdma_nd_addr_gen: N-dimensional strided address stream generator
module tdma_nd_addr_gen
  import tdma_nd_pkg::*;
#(
  parameter int NumDim      = NUM_DIM,
  parameter int AddrWidth   = ADDR_W,
  parameter int DimWidth    = DIM_W,
  parameter int StrideWidth = STRIDE_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [AddrWidth-1:0]          req_addr_i,
  input  logic [NumDim*DimWidth-1:0]    req_shape_i,
  input  logic [NumDim*StrideWidth-1:0] req_stride_i,
  input  logic                          abort_i,
  output logic                          addr_valid_o,
  input  logic                          addr_ready_i,
  output logic [AddrWidth-1:0]          addr_o,
  output logic [NumDim-1:0]             addr_last_o,
  output logic                          done_o,
  output logic                          aborted_o
);
  state_e                         state_q, state_d;
  logic [AddrWidth-1:0]           addr_q, addr_d, inc;
  logic [NumDim*DimWidth-1:0]     shape_q, shape_d;
  logic [NumDim*StrideWidth-1:0]  stride_q, stride_d;
  logic                           done_q, done_d, aborted_q, aborted_d;
  logic [NumDim-1:0]              fin, last, adv;
  logic                           hs, acc, all_last;
  assign req_ready_o  = state_q == IDLE;
  assign addr_valid_o = state_q == RUN;
  assign addr_o       = addr_q;
  assign addr_last_o  = addr_valid_o ? last : '0;
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;
  assign hs           = addr_valid_o & addr_ready_i;
  assign acc          = req_valid_i & req_ready_o;
  assign all_last     = last[NumDim-1];
  for (genvar g = 0; g < NumDim; g++) begin : g_dim
    if (g == 0) begin : g_lo
      assign last[g] = fin[g];
      assign adv[g]  = !fin[g];
    end else begin : g_hi
      assign last[g] = last[g-1] & fin[g];
      assign adv[g]  = last[g-1] & !fin[g];
    end
    tdma_nd_dim_ctr #(.DimWidth(DimWidth)) u_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (acc),
      .inc_i   (hs & !all_last & adv[g]),
      .wrap_i  (hs & !all_last & last[g]),
      .shape_i (shape_q[g*DimWidth +: DimWidth]),
      .final_o (fin[g])
    );
  end
  // stride of the single advancing dimension, sign-extended to address width
  always_comb begin
    inc = '0;
    for (int d = 0; d < NumDim; d++)
      if (adv[d]) inc = AddrWidth'($signed(stride_q[d*StrideWidth +: StrideWidth]));
  end
  // descriptor accept, address advance, completion and abort
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    shape_d   = shape_q;
    stride_d  = stride_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    if (acc) begin
      addr_d   = req_addr_i;
      shape_d  = req_shape_i;
      stride_d = req_stride_i;
      done_d   = req_shape_i == '0;
      state_d  = (req_shape_i == '0) ? IDLE : RUN;
    end else if (state_q == RUN) begin
      addr_d    = (hs && !all_last) ? addr_q + inc : addr_q;
      done_d    = (hs && all_last) || abort_i;
      aborted_d = abort_i && !(hs && all_last);
      state_d   = ((hs && all_last) || abort_i) ? IDLE : RUN;
    end
  end
  // controller state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      shape_q   <= '0;
      stride_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      shape_q   <= shape_d;
      stride_q  <= stride_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
endmodule

// File: tb/tb_tdma_nd_addr_gen.sv
// tb_tdma_nd_addr_gen: directed self-checking bench with a closed-form address model
module tb_tdma_nd_addr_gen;
  typedef struct {
    logic [63:0] a;
    logic [3:0]  l;
  } exp_t;
  logic         clk = 0;
  logic         rst = 0;
  logic         req_valid = 0;
  logic         req_ready_o;
  logic [63:0]  req_addr = '0;
  logic [127:0] req_shape = '0;
  logic [127:0] req_stride = '0;
  logic         abort_i = 0;
  logic         addr_valid_o;
  logic         addr_ready = 1;
  logic [63:0]  addr_o;
  logic [3:0]   addr_last_o;
  logic         done_o, aborted_o;
  exp_t         q[$];
  int           npass = 0, ntot = 0, done_cnt = 0, ab_cnt = 0, hs_cnt = 0;
  logic         exp_done = 0, exp_ab = 0, pstall = 0;
  logic [63:0]  paddr;
  logic [3:0]   plast;
  logic [63:0]  t2a[6] = '{64'h0, 64'h4, 64'h104, 64'h108, 64'h208, 64'h20c};
  logic [3:0]   t2l[6] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'hf};

  tdma_nd_addr_gen dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr), .req_shape_i(req_shape), .req_stride_i(req_stride),
    .abort_i(abort_i), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready),
    .addr_o(addr_o), .addr_last_o(addr_last_o), .done_o(done_o), .aborted_o(aborted_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", n, got, exp);
  endtask

  // address i = start + sum over dims of (times that dim advanced) * stride
  task automatic push_desc(input logic [63:0] a, input logic [127:0] sh, input logic [127:0] st);
    longint eff[4];
    longint p[5];
    exp_t e;
    logic allf;
    p[0] = 1;
    for (int d = 0; d < 4; d++) begin
      eff[d] = (sh[d*32 +: 32] == 0) ? 64'd1 : longint'(sh[d*32 +: 32]);
      p[d+1] = p[d] * eff[d];
    end
    if (sh == 0) return;
    for (longint i = 0; i < p[4]; i++) begin
      e.a = a;
      allf = 1;
      for (int d = 0; d < 4; d++) begin
        e.a += longint'($signed(st[d*32 +: 32])) * (i / p[d] - i / p[d+1]);
        allf &= ((i / p[d]) % eff[d]) == eff[d] - 1;
        e.l[d] = allf;
      end
      q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [127:0] sh, input logic [127:0] st);
    req_addr = a;
    req_shape = sh;
    req_stride = st;
    req_valid = 1;
    cyc();
    req_valid = 0;
  endtask

  task automatic wait_idle(input logic rnd, output int n);
    n = 0;
    while (!req_ready_o && n < 1000) begin
      if (rnd) addr_ready = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    addr_ready = 1;
    if (n >= 1000) begin
      ntot++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
    cyc();
  endtask

  // per-cycle compare of the DUT stream against the model queue
  always @(negedge clk) begin
    exp_t e;
    e.a = '0;
    e.l = '0;
    if (rst) begin
      exp_done = 0;
      exp_ab = 0;
      pstall = 0;
    end else begin
      chk("done", done_o, exp_done);
      chk("aborted", aborted_o, exp_ab);
      chk("req_ready", req_ready_o, !addr_valid_o);
      if (done_o) begin
        done_cnt++;
        if (aborted_o) ab_cnt++;
      end
      if (pstall) begin
        chk("stall_addr", addr_o, paddr);
        chk("stall_last", addr_last_o, plast);
      end
      if (addr_valid_o) begin
        if (q.size() == 0) begin
          ntot++;
          $display("FAIL extra_addr got=%h exp=none", addr_o);
        end else begin
          e = q[0];
          chk("addr", addr_o, e.a);
          chk("last", addr_last_o, e.l);
          if (addr_ready) begin
            void'(q.pop_front());
            hs_cnt++;
          end
        end
      end else chk("last_idle", addr_last_o, 0);
      exp_done = (addr_valid_o & addr_ready & e.l[3]) | (addr_valid_o & abort_i)
               | (req_ready_o & req_valid & (req_shape == 0));
      exp_ab = addr_valid_o & abort_i & !(addr_ready & e.l[3]);
      pstall = addr_valid_o & !addr_ready;
      paddr = addr_o;
      plast = addr_last_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, a0, h0;
    #1 rst = 1;
    #1;
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_valid", addr_valid_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_last", addr_last_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_aborted", aborted_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    cyc();
    // linear 4-element walk, one address per cycle
    d0 = done_cnt;
    push_desc(64'h1000, {32'd1, 32'd1, 32'd1, 32'd4}, {32'd8, 32'd8, 32'd8, 32'd8});
    chk("t1_pin_a3", q[3].a, 64'h1018);
    chk("t1_pin_l3", q[3].l, 4'hf);
    send(64'h1000, {32'd1, 32'd1, 32'd1, 32'd4}, {32'd8, 32'd8, 32'd8, 32'd8});
    wait_idle(0, n);
    chk("t1_cycles", n, 4);
    chk("t1_done", done_cnt - d0, 1);
    // 2x3 with skipped outer dims
    push_desc(64'h0, {32'd0, 32'd0, 32'd3, 32'd2}, {32'd0, 32'd0, 32'h100, 32'd4});
    for (int i = 0; i < 6; i++) begin
      chk("t2_pin_a", q[i].a, t2a[i]);
      chk("t2_pin_l", q[i].l, t2l[i]);
    end
    send(64'h0, {32'd0, 32'd0, 32'd3, 32'd2}, {32'd0, 32'd0, 32'h100, 32'd4});
    wait_idle(0, n);
    chk("t2_cycles", n, 6);
    // negative stride
    push_desc(64'h40, {32'd0, 32'd0, 32'd0, 32'd3}, {32'd0, 32'd0, 32'd0, 32'hfffffff0});
    chk("t3_pin_a2", q[2].a, 64'h20);
    send(64'h40, {32'd0, 32'd0, 32'd0, 32'd3}, {32'd0, 32'd0, 32'd0, 32'hfffffff0});
    wait_idle(0, n);
    // all-zero shape: single done, no addresses
    d0 = done_cnt;
    h0 = hs_cnt;
    send(64'h1234, '0, {32'd1, 32'd1, 32'd1, 32'd1});
    repeat (4) cyc();
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_no_addr", hs_cnt - h0, 0);
    // random consumer stalls
    d0 = done_cnt;
    push_desc(64'h5000, {32'd0, 32'd2, 32'd2, 32'd3}, {32'd0, 32'hfffff000, 32'h100, 32'd8});
    send(64'h5000, {32'd0, 32'd2, 32'd2, 32'd3}, {32'd0, 32'hfffff000, 32'h100, 32'd8});
    wait_idle(1, n);
    chk("t5_drained", q.size(), 0);
    chk("t5_done", done_cnt - d0, 1);
    // abort in IDLE does nothing
    d0 = done_cnt;
    abort_i = 1;
    repeat (2) cyc();
    abort_i = 0;
    cyc();
    chk("idle_abort", done_cnt - d0, 0);
    // abort on the second handshake, then back-to-back descriptor
    d0 = done_cnt;
    a0 = ab_cnt;
    h0 = hs_cnt;
    push_desc(64'h2000, {32'd0, 32'd0, 32'd0, 32'd16}, {32'd0, 32'd0, 32'd0, 32'd4});
    send(64'h2000, {32'd0, 32'd0, 32'd0, 32'd16}, {32'd0, 32'd0, 32'd0, 32'd4});
    cyc();
    abort_i = 1;
    cyc();
    abort_i = 0;
    chk("t6_hs", hs_cnt - h0, 2);
    chk("t6_left", q.size(), 14);
    chk("t6_ready", req_ready_o, 1);
    q.delete();
    push_desc(64'h3000, {32'd0, 32'd0, 32'd0, 32'd2}, {32'd0, 32'd0, 32'd0, 32'd1});
    send(64'h3000, {32'd0, 32'd0, 32'd0, 32'd2}, {32'd0, 32'd0, 32'd0, 32'd1});
    wait_idle(0, n);
    chk("t6_done", done_cnt - d0, 2);
    chk("t6_aborted", ab_cnt - a0, 1);
    // reset mid-run discards silently
    d0 = done_cnt;
    push_desc(64'h7000, {32'd0, 32'd0, 32'd0, 32'd8}, {32'd0, 32'd0, 32'd0, 32'd4});
    send(64'h7000, {32'd0, 32'd0, 32'd0, 32'd8}, {32'd0, 32'd0, 32'd0, 32'd4});
    repeat (2) cyc();
    rst = 1;
    #1;
    chk("t7_valid", addr_valid_o, 0);
    chk("t7_ready", req_ready_o, 1);
    chk("t7_addr", addr_o, 0);
    q.delete();
    cyc();
    rst = 0;
    repeat (3) cyc();
    chk("t7_no_done", done_cnt - d0, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
